// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and defaults for the I/D-cache to physical-memory arbiter.
package cache_mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W       = 16;
    localparam int unsigned DEF_LINE_W       = 128;
    localparam int unsigned DEF_STARVE_LIMIT = 3;

    typedef logic [DEF_ADDR_W-1:0] lc3b_word;
    typedef logic [DEF_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Counter width able to hold 0..limit (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side line-port signals of the arbiter.
interface cache_mem_arbiter_if
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LINE_W = DEF_LINE_W
) ();

    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;

    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter side.
    modport slave (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // Environment side: caches and physical memory.
    modport master (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_mem_arbiter_starve_counter.sv
// Saturating count of D-cache grants made while the I-cache was waiting.
module cache_mem_arbiter_starve_counter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit_c
);

    localparam int unsigned      CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; increment stops at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_at_limit_c = (r_cnt == LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// D-cache wins ties unless the I-cache has been passed over STARVE_LIMIT times.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned LINE_W       = DEF_LINE_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    cache_mem_arbiter_if.slave bus
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;

    logic w_d_req;
    logic w_at_limit;
    logic w_grant_i;
    logic w_grant_d;
    logic w_i_resp;
    logic w_d_resp;

    assign w_d_req = bus.dcache_read || bus.dcache_write;

    cache_mem_arbiter_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .rst          (rst),
        .i_inc        (w_grant_d && bus.icache_read),
        .i_clr        (w_grant_i),
        .o_at_limit_c (w_at_limit)
    );

    // Next-state, grant decision and response routing.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_i_resp     = 1'b0;
        w_d_resp     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_req && !(bus.icache_read && w_at_limit)) begin
                    w_grant_d    = 1'b1;
                    w_next_state = GRANT_D;
                end else if (bus.icache_read) begin
                    w_grant_i    = 1'b1;
                    w_next_state = GRANT_I;
                end
            end
            GRANT_I: begin
                if (bus.pmem_resp) begin
                    w_i_resp     = 1'b1;
                    w_next_state = RELEASE;
                end
            end
            GRANT_D: begin
                if (bus.pmem_resp) begin
                    w_d_resp     = 1'b1;
                    w_next_state = RELEASE;
                end
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register plus the transaction latched from the winner at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_pmem_read    <= 1'b1;
                r_pmem_write   <= 1'b0;
                r_pmem_address <= bus.icache_address;
                r_pmem_wdata   <= '0;
            end else if (w_grant_d) begin
                // A simultaneous read+write request is served as the write-back.
                r_pmem_read    <= !bus.dcache_write;
                r_pmem_write   <= bus.dcache_write;
                r_pmem_address <= bus.dcache_address;
                r_pmem_wdata   <= bus.dcache_wdata;
            end else if (w_i_resp || w_d_resp) begin
                r_pmem_read    <= 1'b0;
                r_pmem_write   <= 1'b0;
            end
        end
    end

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.icache_resp  = w_i_resp;
    assign bus.dcache_resp  = w_d_resp;
    assign bus.icache_rdata = bus.pmem_rdata;
    assign bus.dcache_rdata = bus.pmem_rdata;

endmodule
